// File: rtl/asym_ram.sv
// asym_ram: single-clock simple dual-port RAM with independent
// write and read widths, addressed in RAM_WIDTH-bit units.
// Ports:
//   clk     - clock, all state updates on rising edge
//   rst_n   - asynchronous active-low reset (clears rd_data only)
//   wr_en   - write enable
//   wr_addr - write unit address (low WR_L2 bits ignored)
//   wr_data - WR_IND units, lowest slice to lowest address
//   rd_addr - read unit address (low RD_L2 bits ignored)
//   rd_data - registered read data, one cycle latency, read-first
module asym_ram #(
   parameter int RAM_DEPTH      = 64,
   parameter int RAM_ADDR_WIDTH = 6,
   parameter int WR_WIDTH       = 32,
   parameter int RD_WIDTH       = 16,
   parameter int RAM_WIDTH      = 8,
   parameter int WR_IND         = 4,
   parameter int RD_IND         = 2,
   parameter int WR_L2          = 2,
   parameter int RD_L2          = 1,
   parameter int RAM_RD2WR      = 1,
   parameter int RAM_RD_WIDTH   = RAM_WIDTH * RAM_RD2WR,
   parameter int RAMS_RD_WIDTH  = WR_WIDTH * RAM_RD2WR
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [RAM_ADDR_WIDTH-1:0] wr_addr,
   input  logic [WR_WIDTH-1:0]       wr_data,
   input  logic [RAM_ADDR_WIDTH-1:0] rd_addr,
   output logic [RD_WIDTH-1:0]       rd_data
);

   // One bank per unit of the wider port: every access of either
   // port touches each bank at most once, so each bank is a plain
   // one-write/one-read memory.
   localparam int NB    = WR_IND * (RAM_RD_WIDTH / RAM_WIDTH);
   localparam int NB_L2 = $clog2(NB);
   localparam int ROW_W = (RAM_ADDR_WIDTH > NB_L2) ?
                          (RAM_ADDR_WIDTH - NB_L2) : 1;
   localparam int ROWS  = 1 << ROW_W;

   logic [RAM_ADDR_WIDTH-1:0] wr_base;
   logic [RAM_ADDR_WIDTH-1:0] rd_base;
   logic [ROW_W-1:0]          wr_row;
   logic [ROW_W-1:0]          rd_row;
   logic [NB-1:0]             bank_we;
   logic [RAMS_RD_WIDTH-1:0]  bank_wdata;
   logic [RAMS_RD_WIDTH-1:0]  bank_rdata;
   logic [RD_WIDTH-1:0]       rd_next;

   assign wr_base = (wr_addr >> WR_L2) << WR_L2;
   assign rd_base = (rd_addr >> RD_L2) << RD_L2;
   assign wr_row  = ROW_W'(wr_base >> NB_L2);
   assign rd_row  = ROW_W'(rd_base >> NB_L2);

   // Narrow write steered onto its lane of banks; a write seen
   // while reset is asserted is dropped.
   always_comb begin
      int wl;
      wl = int'(wr_base) % NB;
      bank_wdata = RAMS_RD_WIDTH'(wr_data) << (wl * RAM_WIDTH);
      bank_we    = NB'({WR_IND{1'b1}}) << wl;
      if (!(wr_en && rst_n)) begin
         bank_we = '0;
      end
   end

   // Narrow read picks its lane out of the combined bank output.
   always_comb begin
      int rl;
      rl = int'(rd_base) % NB;
      rd_next = RD_WIDTH'(bank_rdata >> (rl * RAM_WIDTH));
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      logic [RAM_WIDTH-1:0] ram [ROWS];

      always_ff @(posedge clk) begin
         if (bank_we[b]) begin
            ram[wr_row] <= bank_wdata[b*RAM_WIDTH +: RAM_WIDTH];
         end
      end

      assign bank_rdata[b*RAM_WIDTH +: RAM_WIDTH] = ram[rd_row];
   end

   // Bank contents are sampled before the same-edge write lands,
   // giving read-first behaviour on collisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_next;
      end
   end

endmodule

// File: tb/tb_asym_ram.sv
// tb_asym_ram: directed and random checks of asym_ram against a
// unit-array reference model.
module tb_asym_ram;

   localparam int DEPTH = 64;
   localparam int WIND  = 4;
   localparam int RIND  = 2;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [5:0]  rd_addr;
   logic [15:0] rd_data;

   int n_cmp;
   int n_err;

   logic [7:0] mem_m   [DEPTH];
   bit         known_m [DEPTH];

   asym_ram dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_read(input int ra, output logic [15:0] e,
                             output bit ok);
      int rb;
      rb = (ra / RIND) * RIND;
      ok = 1'b1;
      e  = '0;
      for (int i = 0; i < RIND; i++) begin
         e[i*8 +: 8] = mem_m[(rb + i) % DEPTH];
         if (!known_m[(rb + i) % DEPTH]) ok = 1'b0;
      end
   endtask

   task automatic model_write(input int wa, input logic [31:0] wd);
      int wb;
      wb = (wa / WIND) * WIND;
      for (int i = 0; i < WIND; i++) begin
         mem_m[(wb + i) % DEPTH]   = wd[i*8 +: 8];
         known_m[(wb + i) % DEPTH] = 1'b1;
      end
   endtask

   // One clock: drive, predict read-first, check after the edge.
   task automatic cyc(input logic we, input int wa,
                      input logic [31:0] wd, input int ra,
                      input string tag);
      logic [15:0] e;
      bit          ok;
      wr_en   = we;
      wr_addr = 6'(wa);
      wr_data = wd;
      rd_addr = 6'(ra);
      model_read(ra, e, ok);
      @(posedge clk);
      #1;
      if (ok) check(tag, 32'(rd_data), 32'(e));
      if (we) model_write(wa, wd);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i]   = '0;
         known_m[i] = 1'b0;
      end
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", 32'(rd_data), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic little-endian write then two half reads
      cyc(1'b1, 0, 32'hA1B2C3D4, 0, "first_rd");
      cyc(1'b0, 0, 32'h0, 0, "rd0");
      check("rd0_direct", 32'(rd_data), 32'h0000C3D4);
      cyc(1'b0, 0, 32'h0, 2, "rd2");
      check("rd2_direct", 32'(rd_data), 32'h0000A1B2);

      // misaligned addresses
      cyc(1'b1, 5, 32'h11223344, 0, "mis_w");
      cyc(1'b0, 0, 32'h0, 4, "mis_rd4");
      check("mis_rd4_direct", 32'(rd_data), 32'h00003344);
      cyc(1'b0, 0, 32'h0, 7, "mis_rd7");
      check("mis_rd7_direct", 32'(rd_data), 32'h00001122);

      // burst fill and sweep, then wrap
      for (int k = 0; k < 16; k++) begin
         cyc(1'b1, 4 * k, 32'(k), 0, "fill");
      end
      for (int a = 0; a < 64; a += 2) begin
         cyc(1'b0, 0, 32'h0, a, "sweep");
         check("sweep_direct", 32'(rd_data),
               (a % 4 == 0) ? 32'(a / 4) : 32'h0);
      end
      cyc(1'b0, 0, 32'h0, 0, "wrap");
      check("wrap_direct", 32'(rd_data), 32'h0);

      // read-first collision
      cyc(1'b1, 0, 32'hDEADBEEF, 8, "coll_pre");
      cyc(1'b1, 0, 32'h01020304, 0, "coll_same");
      check("coll_same_direct", 32'(rd_data), 32'h0000BEEF);
      cyc(1'b0, 0, 32'h0, 0, "coll_next");
      check("coll_next_direct", 32'(rd_data), 32'h00000304);

      // async reset mid-cycle, write under reset ignored
      cyc(1'b0, 0, 32'h0, 4, "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 32'(rd_data), 32'h0);
      wr_en   = 1'b1;
      wr_addr = 6'd8;
      wr_data = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      check("rst_edge", 32'(rd_data), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wr_en = 1'b0;
      cyc(1'b0, 0, 32'h0, 8, "rst_nowrite");
      check("rst_nowrite_direct", 32'(rd_data), 32'h00000002);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
             $urandom, int'($urandom_range(0, 63)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/asym_ram.md
Name: asym_ram

Overview:
- Single-clock simple dual-port RAM with independent write and read widths.
- Storage is RAM_DEPTH units of RAM_WIDTH bits, addressed in units.
- A write stores WR_IND consecutive units; a read returns RD_IND consecutive units.
- Used as the width-conversion store between the DDR3 user-side datapath and its FIFOs.

Parameters:
RAM_DEPTH, 64, number of RAM_WIDTH-bit storage units
RAM_ADDR_WIDTH, 6, address width in units; 2**RAM_ADDR_WIDTH == RAM_DEPTH
WR_WIDTH, 32, write data width; equals WR_IND*RAM_WIDTH
RD_WIDTH, 16, read data width; equals RD_IND*RAM_WIDTH
RAM_WIDTH, 8, width of one storage unit
WR_IND, 4, units written per write
RD_IND, 2, units read per read
WR_L2, 2, log2(WR_IND); number of write-address low bits ignored
RD_L2, 1, log2(RD_IND); number of read-address low bits ignored
RAM_RD2WR, 1, RD_WIDTH/WR_WIDTH when RD_WIDTH>WR_WIDTH, else 1
RAM_RD_WIDTH, RAM_WIDTH*RAM_RD2WR, per-bank read width (implementation aid)
RAMS_RD_WIDTH, WR_WIDTH*RAM_RD2WR, combined bank read width (implementation aid)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write enable
wr_addr  input  RAM_ADDR_WIDTH  write unit address
wr_data  input  WR_WIDTH  write data
rd_addr  input  RAM_ADDR_WIDTH  read unit address
rd_data  output  RD_WIDTH  registered read data

Behaviour:
- Parameter legality: WR_IND and RD_IND are powers of 2 and ≤ RAM_DEPTH. The widths satisfy WR_WIDTH=WR_IND*RAM_WIDTH and RD_WIDTH=RD_IND*RAM_WIDTH. All three width relations are supported: RD_WIDTH >, =, or < WR_WIDTH.
- Reset: rst_n low forces rd_data to 0 immediately. This is asynchronous and does not wait for clk. Reset is released on the next clk edge with rst_n high. Memory contents are not reset; unwritten locations read as undefined.
- Write:
  - On a rising clk edge with wr_en=1 and rst_n=1, let base = wr_addr with the low WR_L2 bits forced to 0.
  - For i in 0..WR_IND-1: unit[base+i] <= wr_data[i*RAM_WIDTH +: RAM_WIDTH]. Byte order is little-endian: the lowest slice goes to the lowest address.
  - wr_en=0 leaves memory unchanged.
- Read:
  - There is no read enable; a read happens on every rising clk edge while rst_n=1.
  - Let rbase = rd_addr with the low RD_L2 bits forced to 0.
  - rd_data[i*RAM_WIDTH +: RAM_WIDTH] <= unit[rbase+i] for i in 0..RD_IND-1, which is also little-endian.
  - Latency is 1 cycle: the address presented before edge N appears on rd_data after edge N. rd_data holds between edges.
- Read width larger than write width: one read spans RD_WIDTH/WR_WIDTH consecutive write words. The lower-addressed word occupies the low bits.
- Read width smaller than write width: consecutive reads at rbase, rbase+RD_IND, ... return successive slices of a write word, low slice first.
- Simultaneous read and write to overlapping units on the same edge is read-first: rd_data returns the pre-write contents. The new data is visible on the following read.
- Address arithmetic is modulo RAM_DEPTH. No overflow flag. Aligned accesses never straddle the top, because base+IND-1 ≤ RAM_DEPTH-1.
- Reset asserted mid-operation: rd_data clears at once. A write on an edge where rst_n is low is ignored.
- Implementation is inferable block/distributed RAM. The suggested organisation is WR_IND banks of RAM_WIDTH bits, each RAM_DEPTH/WR_IND deep, with a read-side mux or concatenation. Any equivalent structure meeting the above is acceptable.

Test Plan:
- Reset: hold rst_n=0, toggle clk -> rd_data=16'h0000. Assert rst_n low asynchronously mid-cycle after reads -> rd_data drops to 0 before the next edge.
- Write 32'hA1B2C3D4 @0, then read @0 and @2 -> rd_data 16'hC3D4, then 16'hA1B2, each 1 cycle after its address.
- Misalignment:
  - Write 32'h11223344 with wr_addr=5 -> stored at units 4..7.
  - rd_addr=4 -> 16'h3344.
  - rd_addr=7 (aligned to 6) -> 16'h1122.
- Burst fill: write data k at addr 4k for k=0..15, then read addr 0,2,...,62 -> for each k, 16'h(k) (low half of word k) followed by 16'h0000 (high half). Then wrap to addr 0 -> 16'h0000 again. Data persists with wr_en=0.
- Read-first collision: memory @0 = 32'hDEADBEEF. On the same edge, write 32'h01020304 @0 and read @0 -> rd_data=16'hBEEF. Next read @0 -> 16'h0304.
- Parameter variants:
  - RD_WIDTH=64, RD_IND=8, RD_L2=3, RAM_RD2WR=2, same writes (word k at addr 4k) -> read @8 returns {word3, word2}.
  - RD_WIDTH=32, RD_IND=4, RD_L2=2, RAM_RD2WR=1 -> read @4 returns word1.
